random_position_gen: RTL and testbench
======================================

Name: random_position_gen

Overview:
- Upstream feeder of the bonus placement checker. Periodically, or on demand, it draws a pseudo-random grid cell (5-bit column, 4-bit row).
- It rejects cells that are out of range or occupied by querying the map, then publishes the cell with a one-cycle randomRise pulse.
- The downstream checker latches randomX/randomY on that pulse and converts them to pixel coordinates.

Parameters:
- GRID_COLS, 20, valid columns 0..GRID_COLS-1 (max 32)
- GRID_ROWS, 15, valid rows 0..GRID_ROWS-1 (max 16)
- PERIOD_SEC, 8, one_sec pulses between automatic draws (>=1)
- MAX_RETRIES, 8, rejected candidates before fallback (>=1)
- FALLBACK_X, 4, column published when retries are exhausted
- FALLBACK_Y, 4, row published when retries are exhausted
- LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- enable  in  1  generator running; low forces IDLE
- one_sec  in  1  one-cycle tick, once per second
- trigger  in  1  one-cycle request for an immediate draw (e.g. bonus collected)
- cell_occupied  in  1  map answer, valid the cycle after query_valid
- query_valid  out  1  map lookup request
- query_x  out  5  column being queried
- query_y  out  4  row being queried
- randomX  out  5  published column, held between pulses
- randomY  out  4  published row, held between pulses
- randomRise  out  1  one-cycle publish strobe
- busy  out  1  high in DRAW/QUERY/CHECK

Behaviour:
- Reset values: randomX=FALLBACK_X, randomY=FALLBACK_Y, randomRise=0, query_valid=0, query_x=0, query_y=0, busy=0, state=IDLE, sec_cnt=0, retry_cnt=0, LFSR=seed.
- LFSR:
  - 16-bit Galois, taps 16'hB400, advances every non-reset cycle regardless of state.
  - If the state is ever 0, it reloads the seed on the next cycle.
- Candidate: x=lfsr[4:0], y=lfsr[11:8], sampled on entry to DRAW.
- FSM:
  - IDLE: enable=1 -> WAIT, sec_cnt=0.
  - WAIT:
    - trigger -> DRAW.
    - Otherwise on one_sec, sec_cnt++; the tick where sec_cnt==PERIOD_SEC-1 -> DRAW.
    - trigger and one_sec in the same cycle: trigger wins.
  - DRAW:
    - Latch the candidate.
    - If x>=GRID_COLS or y>=GRID_ROWS: retry_cnt++, stay in DRAW with a fresh candidate next cycle.
    - Otherwise -> QUERY.
  - QUERY: query_valid=1 for exactly this cycle, query_x/query_y = candidate -> CHECK.
  - CHECK: sample cell_occupied.
    - If 1: retry_cnt++, -> DRAW.
    - If 0: -> PUBLISH.
  - PUBLISH:
    - randomX/randomY <= candidate, randomRise=1 for this cycle only.
    - Clear retry_cnt and sec_cnt, -> WAIT.
  - Retry exhaustion: any rejection that makes retry_cnt==MAX_RETRIES goes to PUBLISH with FALLBACK_X/FALLBACK_Y instead of the candidate.
- Latency: best case, randomRise is asserted 3 cycles after the DRAW entry cycle (DRAW, QUERY, CHECK, PUBLISH).
- trigger during DRAW/QUERY/CHECK/PUBLISH is ignored (not queued).
- enable low in any state -> IDLE next cycle:
  - no pulse issued, query_valid=0;
  - randomX/randomY hold;
  - counters clear.
- reset mid-draw: all reset values apply next cycle, including outputs returning to the fallback cell.
- Outputs are Moore decodes of registered state/candidate; no combinational path from inputs to outputs.

Optional Feature:
- RANDPOS_EXCLUDE_LAST_EN defined:
  - An in-range candidate equal to the current randomX/randomY is rejected in DRAW (counts as a retry, no query issued).
  - A fallback publish may still equal the last cell.
- Undefined: repeats are allowed; no compare logic.

Decomposition:
- randpos_pkg:
  - state enum (IDLE, WAIT, DRAW, QUERY, CHECK, PUBLISH);
  - LFSR_TAPS=16'hB400, DEFAULT_SEED=16'hACE1;
  - grid width constants X_W=5, Y_W=4.
- Sub-module lfsr16: free-running Galois LFSR with seed parameter, zero-lockup recovery, 16-bit state output.

Test Plan:
- Reset asserted 3 cycles with enable=1 -> during and after: randomX=4, randomY=4, randomRise=0, query_valid=0, busy=0.
- PERIOD_SEC=2, cell_occupied=0, seed chosen so the first candidate is in range -> 2nd one_sec puts DRAW next cycle; randomRise high exactly 3 cycles later for 1 cycle; randomX/randomY match query_x/query_y.
- cell_occupied tied 1, MAX_RETRIES=8 -> 8 rejections (range and occupancy combined), then randomRise with (4,4); query_valid count equals the number of in-range candidates.
- trigger pulsed in WAIT with sec_cnt=1 -> DRAW next cycle; a second trigger during QUERY produces no extra randomRise.
- enable dropped in CHECK -> IDLE next cycle, no randomRise, randomX/randomY unchanged; re-enable restarts a full PERIOD_SEC wait.
- With RANDPOS_EXCLUDE_LAST_EN, force a candidate equal to the last published cell -> rejected without query_valid, retry_cnt+1.

Source files
------------

// File: rtl/randpos_pkg.sv
// Shared types and constants for the random bonus-position generator.
package randpos_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      DRAW,
      QUERY,
      CHECK,
      PUBLISH
   } state_e;

   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam int          X_W          = 5;
   localparam int          Y_W          = 4;

   // Right-shifting Galois step: the bit shifted out folds the taps back in.
   function automatic logic [15:0] lfsrNext(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by DEFAULT_SEED and
// an all-zero state reloads the seed on the next cycle.
module lfsr16
   import randpos_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic [15:0] state_o
);

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = (lfsr_q == 16'h0000) ? SEED_EFF : lfsrNext(lfsr_q);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) lfsr_q <= SEED_EFF;
      else         lfsr_q <= lfsr_d;
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/random_position_gen.sv
// Draws random grid cells, screens them against range and map occupancy, and
// publishes the result with a one-cycle randomRise. Optional: RANDPOS_EXCLUDE_LAST_EN.
module random_position_gen
   import randpos_pkg::*;
#(
   parameter int             GRID_COLS   = 20,
   parameter int             GRID_ROWS   = 15,
   parameter int             PERIOD_SEC  = 8,
   parameter int             MAX_RETRIES = 8,
   parameter logic [X_W-1:0] FALLBACK_X  = 5'd4,
   parameter logic [Y_W-1:0] FALLBACK_Y  = 4'd4,
   parameter logic [15:0]    LFSR_SEED   = 16'hACE1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic           one_sec,
   input  logic           trigger,
   input  logic           cell_occupied,
   output logic           query_valid,
   output logic [X_W-1:0] query_x,
   output logic [Y_W-1:0] query_y,
   output logic [X_W-1:0] randomX,
   output logic [Y_W-1:0] randomY,
   output logic           randomRise,
   output logic           busy
);

   localparam int             SEC_W  = $clog2(PERIOD_SEC + 1);
   localparam int             RET_W  = $clog2(MAX_RETRIES + 1);
   localparam logic [X_W:0]   COLS_L = (X_W + 1)'(GRID_COLS);
   localparam logic [Y_W:0]   ROWS_L = (Y_W + 1)'(GRID_ROWS);

   state_e           state_q, state_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic [RET_W-1:0] retry_q, retry_d, retryInc;
   logic [X_W-1:0]   candX_q, candX_d, randX_q, randX_d;
   logic [Y_W-1:0]   candY_q, candY_d, randY_q, randY_d;
   logic [15:0]      lfsrState;
   logic             inRange, isRepeat, reject;
   logic             unusedLfsrBits;

   lfsr16 #(.SEED(LFSR_SEED)) uLfsr (
      .clk_i   (clk),
      .reset_i (reset),
      .state_o (lfsrState)
   );

   assign unusedLfsrBits = ^{lfsrState[15:12], lfsrState[7:5]};
   assign inRange  = ({1'b0, candX_q} < COLS_L) && ({1'b0, candY_q} < ROWS_L);
`ifdef RANDPOS_EXCLUDE_LAST_EN
   assign isRepeat = (candX_q == randX_q) && (candY_q == randY_q);
`else
   assign isRepeat = 1'b0;
`endif
   assign reject   = !inRange || isRepeat;
   assign retryInc = retry_q + RET_W'(1);

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      retry_d = retry_q;
      candX_d = candX_q;
      candY_d = candY_q;
      randX_d = randX_q;
      randY_d = randY_q;
      case (state_q)
         IDLE: begin
            sec_d   = '0;
            retry_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (trigger) begin
               state_d = DRAW;
            end else if (one_sec) begin
               if (sec_q == SEC_W'(PERIOD_SEC - 1)) begin
                  sec_d   = '0;
                  state_d = DRAW;
               end else begin
                  sec_d = sec_q + SEC_W'(1);
               end
            end
         end
         DRAW: begin
            if (reject) begin
               retry_d = retryInc;
               if (retryInc == RET_W'(MAX_RETRIES)) begin
                  randX_d = FALLBACK_X;
                  randY_d = FALLBACK_Y;
                  state_d = PUBLISH;
               end
            end else begin
               state_d = QUERY;
            end
         end
         QUERY: state_d = CHECK;
         CHECK: begin
            if (cell_occupied) begin
               retry_d = retryInc;
               if (retryInc == RET_W'(MAX_RETRIES)) begin
                  randX_d = FALLBACK_X;
                  randY_d = FALLBACK_Y;
                  state_d = PUBLISH;
               end else begin
                  state_d = DRAW;
               end
            end else begin
               randX_d = candX_q;
               randY_d = candY_q;
               state_d = PUBLISH;
            end
         end
         PUBLISH: begin
            retry_d = '0;
            sec_d   = '0;
            state_d = WAIT;
         end
         default: state_d = IDLE;
      endcase

      // Disable aborts everything without touching the published cell.
      if (!enable) begin
         state_d = IDLE;
         sec_d   = '0;
         retry_d = '0;
         randX_d = randX_q;
         randY_d = randY_q;
      end

      if (state_d == DRAW) begin
         candX_d = lfsrState[4:0];
         candY_d = lfsrState[11:8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sec_q   <= '0;
         retry_q <= '0;
         candX_q <= '0;
         candY_q <= '0;
         randX_q <= FALLBACK_X;
         randY_q <= FALLBACK_Y;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         retry_q <= retry_d;
         candX_q <= candX_d;
         candY_q <= candY_d;
         randX_q <= randX_d;
         randY_q <= randY_d;
      end
   end

   assign query_valid = (state_q == QUERY);
   assign query_x     = query_valid ? candX_q : '0;
   assign query_y     = query_valid ? candY_q : '0;
   assign randomX     = randX_q;
   assign randomY     = randY_q;
   assign randomRise  = (state_q == PUBLISH);
   assign busy        = (state_q == DRAW) || (state_q == QUERY) || (state_q == CHECK);

endmodule

// File: tb/tb_random_position_gen.sv
// Self-checking bench: reset vector table plus randomized draws predicted by a
// transaction-level model of the candidate walk.
module tb_random_position_gen;

   localparam int PERIOD = 2;
   localparam int MAXR   = 8;
   localparam int COLS   = 20;
   localparam int ROWS   = 15;
   localparam int FBX    = 4;
   localparam int FBY    = 4;
   localparam int MAXCYC = 8000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic       one_sec = 1'b0;
   logic       trigger = 1'b0;
   logic       cell_occupied = 1'b0;
   logic       query_valid;
   logic [4:0] query_x;
   logic [3:0] query_y;
   logic [4:0] randomX;
   logic [3:0] randomY;
   logic       randomRise;
   logic       busy;

   // The DUT gets a zero seed, so it must run from the 16'hACE1 replacement.
   random_position_gen #(
      .GRID_COLS   (COLS),
      .GRID_ROWS   (ROWS),
      .PERIOD_SEC  (PERIOD),
      .MAX_RETRIES (MAXR),
      .FALLBACK_X  (5'd4),
      .FALLBACK_Y  (4'd4),
      .LFSR_SEED   (16'h0000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .one_sec       (one_sec),
      .trigger       (trigger),
      .cell_occupied (cell_occupied),
      .query_valid   (query_valid),
      .query_x       (query_x),
      .query_y       (query_y),
      .randomX       (randomX),
      .randomY       (randomY),
      .randomRise    (randomRise),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL timeout: simulation did not finish, required finish before 50000 cycles");
      $fatal(1);
   end

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int lfsrAt [0:MAXCYC];
   int lastX  = FBX;
   int lastY  = FBY;

   int expQv [0:63];
   int expQx [0:63];
   int expQy [0:63];
   int occ   [0:63];
   int pOff, pubX, pubY, nQ;

   typedef struct {
      logic rst;
      logic en;
      int   rx;
      int   ry;
      int   rise;
      int   qv;
      int   bsy;
   } vec_t;

   typedef struct {
      bit useTrig;
      bit preTick;
      bit allOcc;
      bit trigInQuery;
   } scen_t;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic advanceCycle();
      logic r;
      r = reset;
      @(posedge clk);
      #1;
      if (r) cyc = 0;
      else   cyc++;
   endtask

   task automatic idleCheck();
      checkOutput("idle_busy", int'(busy), 0);
      checkOutput("idle_rise", int'(randomRise), 0);
      checkOutput("idle_query_valid", int'(query_valid), 0);
      checkOutput("idle_randomX", int'(randomX), lastX);
   endtask

   task automatic applyStimulus(input vec_t v);
      reset  = v.rst;
      enable = v.en;
      advanceCycle();
      checkOutput("vec_randomX", int'(randomX), v.rx);
      checkOutput("vec_randomY", int'(randomY), v.ry);
      checkOutput("vec_rise", int'(randomRise), v.rise);
      checkOutput("vec_query_valid", int'(query_valid), v.qv);
      checkOutput("vec_query_x", int'(query_x), 0);
      checkOutput("vec_busy", int'(busy), v.bsy);
   endtask

   // Walk the candidate sequence starting at DRAW cycle d and record when each
   // query and the final publish should appear, relative to d.
   task automatic predictDraw(input int d, input bit allOcc);
      int  retries, t, v, cx, cy;
      bit  done, rej;
      for (int i = 0; i < 64; i++) begin
         expQv[i] = 0; expQx[i] = 0; expQy[i] = 0;
         occ[i]   = allOcc ? 1 : int'($urandom_range(0, 1));
      end
      retries = 0; t = 0; done = 0; nQ = 0;
      while (!done) begin
         v   = lfsrAt[d + t - 1];
         cx  = v & 31;
         cy  = (v >> 8) & 15;
         rej = (cx >= COLS) || (cy >= ROWS);
`ifdef RANDPOS_EXCLUDE_LAST_EN
         if (!rej && cx == lastX && cy == lastY) rej = 1;
`endif
         if (rej) begin
            retries++;
            if (retries == MAXR) begin
               pOff = t + 1; pubX = FBX; pubY = FBY; done = 1;
            end else begin
               t = t + 1;
            end
         end else begin
            expQv[t + 1] = 1; expQx[t + 1] = cx; expQy[t + 1] = cy; nQ++;
            if (occ[t + 2] != 0) begin
               retries++;
               if (retries == MAXR) begin
                  pOff = t + 3; pubX = FBX; pubY = FBY; done = 1;
               end else begin
                  t = t + 3;
               end
            end else begin
               pOff = t + 3; pubX = cx; pubY = cy; done = 1;
            end
         end
      end
   endtask

   task automatic followDraw(input bit trigInQuery, input int lastO);
      int qSeen;
      bit trigDone;
      qSeen = 0; trigDone = 0;
      for (int o = 0; o <= lastO; o++) begin
         cell_occupied = occ[o][0];
         trigger = trigInQuery && (expQv[o] != 0) && !trigDone;
         if (trigger) trigDone = 1;
         checkOutput("busy", int'(busy), (o < pOff) ? 1 : 0);
         checkOutput("query_valid", int'(query_valid), expQv[o]);
         checkOutput("query_x", int'(query_x), expQx[o]);
         checkOutput("query_y", int'(query_y), expQy[o]);
         checkOutput("randomRise", int'(randomRise), (o == pOff) ? 1 : 0);
         checkOutput("randomX", int'(randomX), (o >= pOff) ? pubX : lastX);
         checkOutput("randomY", int'(randomY), (o >= pOff) ? pubY : lastY);
         qSeen += int'(query_valid);
         if (o < lastO) advanceCycle();
      end
      trigger = 1'b0;
      cell_occupied = 1'b0;
      if (lastO == pOff) begin
         checkOutput("query_count", qSeen, nQ);
         lastX = pubX;
         lastY = pubY;
      end
   endtask

   // From WAIT with the second counter at zero, bring the DUT into DRAW.
   task automatic startDraw(input bit useTrig, input bit preTick, output int d);
      int k;
      if (useTrig) begin
         if (preTick) begin
            one_sec = 1'b1; idleCheck(); advanceCycle(); one_sec = 1'b0;
         end
         k = int'($urandom_range(0, 2));
         for (int i = 0; i < k; i++) begin
            idleCheck(); advanceCycle();
         end
         trigger = 1'b1;
         one_sec = 1'($urandom_range(0, 1));
         idleCheck(); advanceCycle();
         trigger = 1'b0; one_sec = 1'b0;
      end else begin
         for (int n = 0; n < PERIOD; n++) begin
            k = int'($urandom_range(0, 3));
            for (int i = 0; i < k; i++) begin
               idleCheck(); advanceCycle();
            end
            one_sec = 1'b1; idleCheck(); advanceCycle(); one_sec = 1'b0;
         end
      end
      d = cyc;
   endtask

   task automatic fullDraw(input scen_t s);
      int d;
      startDraw(s.useTrig, s.preTick, d);
      predictDraw(d, s.allOcc);
      followDraw(s.trigInQuery, pOff);
      for (int i = 0; i < 2; i++) begin
         advanceCycle(); idleCheck();
      end
   endtask

   vec_t  vecs [0:5];
   scen_t scens [0:2];
   scen_t rs;
   int    d, dropAt;

   initial begin
      lfsrAt[0] = 'hACE1;
      for (int i = 1; i <= MAXCYC; i++)
         lfsrAt[i] = (lfsrAt[i-1] >> 1) ^ (((lfsrAt[i-1] & 1) != 0) ? 'hB400 : 0);

      vecs[0] = '{1'b1, 1'b1, 4, 4, 0, 0, 0};
      vecs[1] = '{1'b1, 1'b1, 4, 4, 0, 0, 0};
      vecs[2] = '{1'b1, 1'b1, 4, 4, 0, 0, 0};
      vecs[3] = '{1'b0, 1'b0, 4, 4, 0, 0, 0};
      vecs[4] = '{1'b0, 1'b1, 4, 4, 0, 0, 0};
      vecs[5] = '{1'b0, 1'b1, 4, 4, 0, 0, 0};

      scens[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
      scens[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
      scens[2] = '{1'b0, 1'b0, 1'b1, 1'b0};

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      for (int i = 0; i < 3; i++) fullDraw(scens[i]);
      for (int i = 0; i < 25; i++) begin
         rs.useTrig     = 1'($urandom_range(0, 1));
         rs.preTick     = 1'($urandom_range(0, 1));
         rs.allOcc      = ($urandom_range(0, 3) == 0);
         rs.trigInQuery = 1'($urandom_range(0, 1));
         fullDraw(rs);
      end

      // Abort by dropping enable in the first CHECK (or in DRAW if none).
      startDraw(1'b1, 1'b1, d);
      predictDraw(d, 1'b0);
      dropAt = 0;
      for (int o = 63; o >= 1; o--) if (expQv[o] != 0 && o < pOff) dropAt = o + 1;
      followDraw(1'b0, dropAt);
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         advanceCycle(); idleCheck();
         checkOutput("drop_randomY", int'(randomY), lastY);
      end
      enable = 1'b1;
      advanceCycle(); idleCheck();
      one_sec = 1'b1; advanceCycle(); one_sec = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idleCheck(); advanceCycle();
      end
      one_sec = 1'b1; idleCheck(); advanceCycle(); one_sec = 1'b0;
      predictDraw(cyc, 1'b0);
      followDraw(1'b0, pOff);
      advanceCycle(); idleCheck();

      // Reset in the middle of a draw returns everything to the fallback cell.
      startDraw(1'b1, 1'b0, d);
      predictDraw(d, 1'b0);
      followDraw(1'b0, 1);
      reset = 1'b1;
      advanceCycle();
      lastX = FBX; lastY = FBY;
      checkOutput("rst_randomX", int'(randomX), FBX);
      checkOutput("rst_randomY", int'(randomY), FBY);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_query_valid", int'(query_valid), 0);
      checkOutput("rst_query_x", int'(query_x), 0);
      checkOutput("rst_rise", int'(randomRise), 0);
      reset = 1'b0;
      advanceCycle(); idleCheck();
      fullDraw(scens[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
